// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcodes, state codes, select encodings and strobe bundle
//   for the multi-cycle RV32I controller. The TRAP state code (11) exists
//   only when MC_CTRL_TRAP_EN is defined.
package rv_ctrl_pkg;
    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_ST  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_OUT = 2'b01;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_WB_MEM   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
`ifdef MC_CTRL_TRAP_EN
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
`else
        ST_JAL      = 4'd10
`endif
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    function automatic logic is_mem_state(state_e s);
        return s inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
    endfunction
endpackage

// File: rtl/multicycle_control_wait.sv
// mc_wait_counter: saturating memory wait counter.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear to zero (wins over en_i)
//   en_i       : count one wait cycle, saturating at MAX_WAIT
//   timeout_o  : high in the wait cycle that brings the count to MAX_WAIT
module mc_wait_counter #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);
    localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count_q, count_d;

    assign count_d   = clr_i ? '0 : (en_i && count_q != MAX_C) ? count_q + 1'b1 : count_q;
    assign timeout_o = en_i && (count_q >= MAX_C - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I main controller (FETCH/DECODE/EXEC/MEM/WB).
//   Inputs : clk, rst (sync, active-high), instr[ILEN], zero, mem_ready
//   Outputs: mem_req, mem_write, iord, ir_write, pc_write, pc_src[2], alu_src_a[2],
//            alu_src_b[2], alu_op[2], reg_write, mem_to_reg[2], state_o[4], fault
//   MC_CTRL_TRAP_EN: adds TRAP state for illegal opcodes and memory timeouts
//   (sticky fault); without it illegal opcodes act as NOP and stalls wait forever.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int ILEN     = 32,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ILEN-1:0] instr,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_write,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            reg_write,
    output logic [1:0]      mem_to_reg,
    output logic [3:0]      state_o,
    output logic            fault
);
    state_e     state_q, state_d, stall_s, illegal_s;
    ctrl_t      c;
    logic [6:0] op;
    logic       timeout, unused_ok;

    assign op = instr[6:0];

    mc_wait_counter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wait (
        .clk       (clk),
        .rst       (rst),
        .clr_i     ((c.mem_req && mem_ready) || (is_mem_state(state_d) && state_d != state_q)),
        .en_i      (c.mem_req && !mem_ready),
        .timeout_o (timeout)
    );

`ifdef MC_CTRL_TRAP_EN
    logic fault_q, fault_d;
    assign stall_s   = timeout ? ST_TRAP : state_q;
    assign illegal_s = ST_TRAP;
    assign fault_d   = fault_q || state_d == ST_TRAP;
    assign fault     = fault_q && !rst;
    assign unused_ok = ^instr[ILEN-1:7];
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end
`else
    assign stall_s   = state_q;
    assign illegal_s = ST_FETCH;
    assign fault     = 1'b0;
    assign unused_ok = ^{instr[ILEN-1:7], timeout};
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        c       = '0;
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_4;
                c.alu_op    = ALU_ADD;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
                c.pc_src    = PCSRC_ALU;
                state_d     = mem_ready ? ST_DECODE : stall_s;
            end
            ST_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                state_d     = op == OP_R   ? ST_EXEC_R :
                              op == OP_I   ? ST_EXEC_I :
                              (op == OP_LD || op == OP_ST) ? ST_MEM_ADDR :
                              op == OP_BR  ? ST_BRANCH :
                              op == OP_JAL ? ST_JAL : illegal_s;
            end
            ST_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_FN;
                state_d     = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FN;
                state_d     = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_ALU;
                state_d      = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                state_d     = op == OP_LD ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                state_d   = mem_ready ? ST_WB_MEM : stall_s;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_MDR;
                state_d      = ST_FETCH;
            end
            ST_MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                state_d     = mem_ready ? ST_FETCH : stall_s;
            end
            ST_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PCSRC_OUT;
                c.pc_write  = zero;
                state_d     = ST_FETCH;
            end
            ST_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_src     = PCSRC_OUT;
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_PC4;
                state_d      = ST_FETCH;
            end
`ifdef MC_CTRL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset forces every strobe low combinationally so a pending access drops at once.
    assign {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
            alu_src_b, alu_op, reg_write, mem_to_reg} = rst ? '0 : c;
    assign state_o = rst ? 4'd0 : state_q;
endmodule
